// File: rtl/mem_responder.sv
// Word-addressed memory slave: accepts one read/write per request and returns a one-cycle ready/abort pulse.
// Optional wait states before each response are enabled by defining MEM_WAIT_STATE_EN.
module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 5
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           data_write,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic [31:0]           data_read,
  output logic                  ready,
  output logic                  abort,
  output logic                  busy
);

  localparam int DATA_W = 32;
  localparam int WORDS  = 1 << DEPTH_LOG2;

`ifdef MEM_WAIT_STATE_EN
  localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  logic [CNT_W-1:0] cnt_q;
`else
  typedef enum logic {IDLE, RESP} state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [WORDS];
  logic [31:0]       addr_p0;
  logic              we_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              capture;
  logic              commit;
  logic              load_ok;
  logic [31:0]       eff_addr;
  logic              eff_we;
  logic [DATA_W-1:0] eff_wdata;

  // Misaligned or beyond the implemented word range.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return a[DEPTH_LOG2+1:2];
  endfunction

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
`ifdef MEM_WAIT_STATE_EN
          if (WAIT_CYCLES > 0) state_d = WAIT;
          else                 state_d = RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef MEM_WAIT_STATE_EN
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the write commits on the capture edge itself, so use the live bus there.
  always_comb begin
    eff_addr  = (state_q == IDLE) ? addr       : addr_p0;
    eff_we    = (state_q == IDLE) ? we         : we_p0;
    eff_wdata = (state_q == IDLE) ? data_write : wdata_p0;
    commit    = !rst && (state_d == RESP) && (state_q != RESP) && eff_we && !addr_err(eff_addr);
    load_ok   = (state_q == IDLE) && !req && load_en;
  end

  always_ff @(posedge clk1) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef MEM_WAIT_STATE_EN
  always_ff @(posedge clk1) begin
    if (rst)                                      cnt_q <= '0;
    else if (capture)                             cnt_q <= CNT_W'(WAIT_CYCLES - 1);
    else if ((state_q == WAIT) && (cnt_q != '0))  cnt_q <= cnt_q - CNT_W'(1);
  end
`endif

  // Capture stage: request fields held for the rest of the access.
  always_ff @(posedge clk1) begin
    if (capture) begin
      addr_p0  <= addr;
      we_p0    <= we;
      wdata_p0 <= data_write;
    end
  end

  always_ff @(posedge clk1) begin
    if (commit)       mem[word_idx(eff_addr)] <= eff_wdata;
    else if (load_ok) mem[load_addr]          <= load_data;
  end

  // Response stage.
  always_comb begin
    busy      = (state_q != IDLE);
    ready     = (state_q == RESP) && !addr_err(addr_p0);
    abort     = (state_q == RESP) &&  addr_err(addr_p0);
    data_read = '0;
    if (ready && !we_p0) data_read = mem[word_idx(addr_p0)];
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a word-array reference model.
module tb_mem_responder;

  localparam int WC    = 2;
  localparam int DL2   = 5;
  localparam int WORDS = 1 << DL2;
`ifdef MEM_WAIT_STATE_EN
  localparam int LAT = 1 + WC;
`else
  localparam int LAT = 1;
`endif

  logic           clk1 = 1'b0;
  logic           rst, req, we, load_en;
  logic [31:0]    addr, data_write, load_data, data_read;
  logic [DL2-1:0] load_addr;
  logic           ready, abort, busy;

  logic [31:0] model_mem [WORDS];
  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.WAIT_CYCLES(WC), .DEPTH_LOG2(DL2)) dut (
    .clk1(clk1), .rst(rst), .req(req), .we(we), .addr(addr),
    .data_write(data_write), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .data_read(data_read), .ready(ready),
    .abort(abort), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * WORDS);
  endfunction

  task automatic load(input int idx, input logic [31:0] d);
    @(negedge clk1);
    load_en = 1'b1; load_addr = DL2'(idx); load_data = d;
    @(posedge clk1);
    #1 load_en = 1'b0;
    model_mem[idx] = d;
  endtask

  // One complete access; returns at the falling edge of the idle cycle that follows RESP.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input bit hold_load);
    bit          bad;
    logic [31:0] exp_rd;
    bad    = is_bad(a);
    exp_rd = (!w && !bad) ? model_mem[a / 4] : 32'h0;
    @(negedge clk1);
    req = 1'b1; we = w; addr = a; data_write = d;
    @(posedge clk1);
    #1;
    req = 1'b0; we = $urandom; addr = $urandom; data_write = $urandom;
    if (hold_load) begin
      load_en = 1'b1; load_addr = 7; load_data = 32'h1;
    end
    for (int c = 1; c < LAT; c++) begin
      @(negedge clk1);
      chk("wait_busy", busy, 1'b1);
      chk("wait_ready", ready, 1'b0);
      chk("wait_abort", abort, 1'b0);
    end
    @(negedge clk1);
    chk("resp_ready", ready, !bad);
    chk("resp_abort", abort, bad);
    chk("resp_data", data_read, exp_rd);
    chk("resp_busy", busy, 1'b1);
    @(posedge clk1);
    #1 load_en = 1'b0;
    @(negedge clk1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", ready, 1'b0);
    chk("idle_data", data_read, 32'h0);
    if (w && !bad) model_mem[a / 4] = d;
  endtask

  initial begin
    logic [31:0] ra;
    int          r;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; data_write = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("rst_ready", ready, 1'b0);
    chk("rst_abort", abort, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", data_read, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < WORDS; i++) load(i, $urandom);

    // Directed read of a preloaded word, latency checked inside access.
    load(3, 32'hE2900F0F);
    access(1'b0, 32'h0000000C, 32'h0, 1'b0);

    access(1'b1, 32'h00000010, 32'hFFFFFFF0, 1'b0);
    access(1'b0, 32'h00000010, 32'h0, 1'b0);

    access(1'b0, 32'h00000006, 32'h0, 1'b0);
    access(1'b1, 32'h00000080, 32'h12345678, 1'b0);
    access(1'b0, 32'h00000000, 32'h0, 1'b0);

    // Reset in the middle of a write must drop it.
    load(5, 32'h0000000F);
    @(negedge clk1);
    req = 1'b1; we = 1'b1; addr = 32'h14; data_write = 32'hDEADBEEF;
`ifdef MEM_WAIT_STATE_EN
    @(posedge clk1);
    #1 req = 1'b0;
    @(negedge clk1);
    rst = 1'b1;
`else
    rst = 1'b1;
`endif
    @(posedge clk1);
    #1 rst = 1'b0; req = 1'b0;
    @(negedge clk1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ready", ready, 1'b0);
    chk("rst_mid_abort", abort, 1'b0);
    access(1'b0, 32'h14, 32'h0, 1'b0);

    // Preload strobe ignored while busy, honoured in idle.
    load(7, 32'hA5A5A5A5);
    access(1'b0, 32'h0, 32'h0, 1'b1);
    access(1'b0, 32'h1C, 32'h0, 1'b0);
    load(7, 32'h00000001);
    access(1'b0, 32'h1C, 32'h0, 1'b0);

    // Back-to-back reads with req held high.
    @(negedge clk1);
    req = 1'b1; we = 1'b0; addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk1);
      for (int c = 1; c < LAT; c++) begin
        @(negedge clk1);
        chk("b2b_wait_ready", ready, 1'b0);
      end
      @(negedge clk1);
      chk("b2b_ready", ready, 1'b1);
      chk("b2b_data", data_read, model_mem[0]);
      @(negedge clk1);
      chk("b2b_idle_busy", busy, 1'b0);
      chk("b2b_idle_ready", ready, 1'b0);
      if (k == 2) req = 1'b0;
    end

    // Randomized mix of good, misaligned and out-of-range accesses plus idle preloads.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      ra = 4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3);
      else if (r == 1) ra = $urandom | (32'h1 << $urandom_range(DL2 + 2, 31));
      else             ra = 4 * $urandom_range(0, WORDS - 1);
      if (r == 9) load($urandom_range(0, WORDS - 1), $urandom);
      access($urandom_range(0, 1), ra, $urandom, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response (used only when wait states are enabled, see REQ-027).
REQ-002 SHALL have parameter DEPTH_LOG2, default 5, log2 of word count (32 words x 32 bits).
REQ-003 SHALL have port clk1  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  1  access request from the address register side.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  32  byte address (the ar bus).
REQ-008 SHALL have port data_write  input  32  write data; sampled with req.
REQ-009 SHALL have port load_en  input  1  test preload strobe.
REQ-010 SHALL have port load_addr  input  DEPTH_LOG2  preload word index.
REQ-011 SHALL have port load_data  input  32  preload word.
REQ-012 SHALL have port data_read  output  32  read data, valid while ready=1 and we=0.
REQ-013 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-014 SHALL have port abort  output  1  one-cycle error pulse, replaces ready.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 IDLE: on an edge with req=1, SHALL capture addr, we and data_write, then go to WAIT if the wait count is nonzero, else to RESP.
REQ-018 WAIT: SHALL decrement a counter loaded with WAIT_CYCLES-1 on entry, and go to RESP on the edge at which the counter is 0.
REQ-019 RESP: SHALL assert exactly one of ready/abort for exactly one cycle, then return to IDLE.
REQ-020 Latency SHALL be 1+W cycles from the req-sampling edge to ready, where W is the wait count in effect.
REQ-021 Word index SHALL be the captured addr[DEPTH_LOG2+1:2].
REQ-022 abort SHALL be raised instead of ready when captured addr[1:0]!=0 or when any captured addr bit above DEPTH_LOG2+1 is nonzero; an aborted write SHALL NOT modify memory, and an aborted read SHALL drive data_read=0.
REQ-023 A write SHALL commit on the edge that enters RESP; a read SHALL present the memory word in RESP; data_read SHALL be 0 outside RESP-read.
REQ-024 Changes on req/addr/we/data_write after capture SHALL be ignored until IDLE is re-entered; req held high through RESP SHALL start a new access on the IDLE edge that follows (back-to-back accesses, one idle cycle between them).
REQ-025 load_en SHALL write load_data to load_addr only in IDLE with req=0, and SHALL be ignored otherwise; if load_en and req are both high in IDLE, req wins.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, ready=0, abort=0, busy=0, data_read=0 and clear the wait counter; an in-flight access SHALL be dropped with no memory write and no ready; memory contents SHALL be preserved.

Configuration
REQ-027 Macro MEM_WAIT_STATE_EN: when defined, SHALL include the WAIT state and counter with W=WAIT_CYCLES (WAIT_CYCLES=0 behaves as when undefined); when undefined, SHALL omit WAIT and counter logic, go IDLE->RESP directly with W=0, and ignore WAIT_CYCLES.

Verification
REQ-028 Preload word 3=32'hE2900F0F, req=1 we=0 addr=32'h0000000C -> ready=1, data_read=32'hE2900F0F, abort=0; 1 cycle after capture when the macro is undefined, 3 cycles after capture when defined with WAIT_CYCLES=2.
REQ-029 Write addr=32'h00000010 data_write=32'hFFFFFFF0, then read the same address -> read returns 32'hFFFFFFF0.
REQ-030 Read addr=32'h00000006 -> abort pulse, data_read=0, ready=0; write to addr=32'h00000080 -> abort pulse, word 0 unchanged.
REQ-031 rst=1 during WAIT of a write to word 5 (preloaded 32'h0000000F) -> no ready, busy=0 next cycle, word 5 still reads 32'h0000000F.
REQ-032 load_en=1 while busy=1 (load_addr=7, load_data=32'h1) -> word 7 unchanged; same load in IDLE with req=0 -> word 7 reads 32'h00000001.
REQ-033 req held high for 3 reads of addr=0 -> 3 ready pulses, each followed by one idle cycle.
